seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 44 ++++
 rtl/seg_text_streamer.sv | 113 +++++++++++
 rtl/seg_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment table,
// ASCII helpers and the text-record FSM state encoding.
package seg_pkg;

    // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_DIGIT = 2'd1,
        SEND_CR    = 2'd2,
        SEND_LF    = 2'd3
    } text_state_t;

    // Hex nibble to upper-case ASCII character
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

    // Character emitted for one digit: a space when the digit is blanked
    function automatic logic [7:0] text_char(input logic [3:0] nib, input logic blanked);
        logic [7:0] chr;
        if (blanked) begin
            chr = ASCII_SP;
        end else begin
            chr = hex_to_ascii(nib);
        end
        return chr;
    endfunction

endpackage

// File: rtl/seg_text_streamer.sv
// Emits one ASCII record (digits MSD first, then CR LF) per frame on a
// valid/ready byte stream. A frame that arrives while a record is still in
// flight is dropped entirely so records never interleave.
module seg_text_streamer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

    text_state_t               state_r, state_s;
    logic [IDX_W-1:0]          idx_r, idx_s;
    logic [IDX_W-1:0]          idx_dec_s;
    logic [4*NUM_DIGITS-1:0]   text_r, text_s;
    logic [NUM_DIGITS-1:0]     mask_r, mask_s;
    logic [7:0]                tx_data_r, tx_data_s;
    logic                      tx_valid_r, tx_valid_s;

    assign idx_dec_s = idx_r - 1'b1;

    // Next-state and next-output logic of the text FSM
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        text_s     = text_r;
        mask_s     = mask_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    text_s     = data;
                    mask_s     = blank_mask;
                    idx_s      = IDX_TOP;
                    state_s    = SEND_DIGIT;
                    tx_valid_s = 1'b1;
                    tx_data_s  = text_char(data[4*(NUM_DIGITS-1) +: 4],
                                           blank_mask[NUM_DIGITS-1]);
                end else begin
                    tx_valid_s = 1'b0;
                end
            end
            SEND_DIGIT: begin
                if (tx_ready) begin
                    if (idx_r == {IDX_W{1'b0}}) begin
                        state_s   = SEND_CR;
                        tx_data_s = ASCII_CR;
                    end else begin
                        idx_s     = idx_dec_s;
                        tx_data_s = text_char(text_r[4*int'(idx_dec_s) +: 4],
                                              mask_r[idx_dec_s]);
                    end
                end else begin
                    state_s = SEND_DIGIT;
                end
            end
            SEND_CR: begin
                if (tx_ready) begin
                    state_s   = SEND_LF;
                    tx_data_s = ASCII_LF;
                end else begin
                    state_s = SEND_CR;
                end
            end
            SEND_LF: begin
                if (tx_ready) begin
                    state_s    = IDLE;
                    tx_valid_s = 1'b0;
                end else begin
                    state_s = SEND_LF;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
            end
        endcase
    end

    // Text FSM state, text shadow and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= {IDX_W{1'b0}};
            text_r     <= {(4*NUM_DIGITS){1'b0}};
            mask_r     <= {NUM_DIGITS{1'b0}};
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            text_r     <= text_s;
            mask_r     <= mask_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with anti-ghosting blank interval,
// frame-coherent input snapshots, leading-zero blanking and a per-frame
// ASCII text record for the UART path.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int SCAN_DIV        = 32768,
    parameter int BLANK_CYCLES    = 64,
    parameter int SEG_ACTIVE_LOW  = 1,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      lz_blank,
    output logic [NUM_DIGITS-1:0]     SEG_S,
    output logic [7:0]                SEG,
    output logic                      frame_start,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DIG_W  = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF =
        (SEL_ACTIVE_HIGH != 0) ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};

    logic [SLOT_W-1:0]         slot_cnt_r, slot_next_s;
    logic [DIG_W-1:0]          digit_r, digit_next_s;
    logic                      frame_tick_s;
    logic [4*NUM_DIGITS-1:0]   data_sh_r;
    logic [NUM_DIGITS-1:0]     dp_sh_r;
    logic                      lz_sh_r;
    logic                      frame_start_r;
    logic [NUM_DIGITS-1:0]     sel_r, sel_next_s, sel_hot_s;
    logic [7:0]                seg_r, seg_next_s, seg_hot_s;
    logic [3:0]                nib_s;
    logic [NUM_DIGITS-1:0]     shadow_mask_s;
    logic [NUM_DIGITS-1:0]     live_mask_s;
    logic                      sh_run_s;
    logic                      live_run_s;

    // Boundary is the edge leaving slot 0 of digit 0 (also the first edge after reset)
    assign frame_tick_s = (slot_cnt_r == {SLOT_W{1'b0}}) && (digit_r == {DIG_W{1'b0}});

    // Slot counter and digit index advance
    always_comb begin
        slot_next_s  = slot_cnt_r;
        digit_next_s = digit_r;
        if (slot_cnt_r == SLOT_LAST) begin
            slot_next_s = {SLOT_W{1'b0}};
            if (digit_r == DIG_LAST) begin
                digit_next_s = {DIG_W{1'b0}};
            end else begin
                digit_next_s = digit_r + 1'b1;
            end
        end else begin
            slot_next_s = slot_cnt_r + 1'b1;
        end
    end

    // Leading-zero masks: digit k blanks when all nibbles k..top are zero (digit 0 never)
    always_comb begin
        shadow_mask_s = {NUM_DIGITS{1'b0}};
        live_mask_s   = {NUM_DIGITS{1'b0}};
        sh_run_s      = 1'b1;
        live_run_s    = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            sh_run_s         = sh_run_s & (data_sh_r[4*k +: 4] == 4'h0);
            live_run_s       = live_run_s & (data[4*k +: 4] == 4'h0);
            shadow_mask_s[k] = lz_sh_r & sh_run_s;
            live_mask_s[k]   = lz_blank & live_run_s;
        end
    end

    // Next select/segment pattern for the current slot position
    always_comb begin
        nib_s      = data_sh_r[4*int'(digit_r) +: 4];
        sel_hot_s  = {NUM_DIGITS{1'b0}};
        seg_hot_s  = 8'h00;
        sel_next_s = SEL_OFF;
        seg_next_s = SEG_OFF;
        if (slot_cnt_r < BLANK_END) begin
            sel_next_s = SEL_OFF;
            seg_next_s = SEG_OFF;
        end else begin
            sel_hot_s[digit_r] = 1'b1;
            seg_hot_s[7]       = dp_sh_r[digit_r];
            if (shadow_mask_s[digit_r]) begin
                seg_hot_s[6:0] = 7'h00;
            end else begin
                seg_hot_s[6:0] = SEG_TABLE[nib_s];
            end
            sel_next_s = (SEL_ACTIVE_HIGH != 0) ? sel_hot_s : ~sel_hot_s;
            seg_next_s = (SEG_ACTIVE_LOW != 0) ? ~seg_hot_s : seg_hot_s;
        end
    end

    // Scan position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            digit_r    <= {DIG_W{1'b0}};
        end else begin
            slot_cnt_r <= slot_next_s;
            digit_r    <= digit_next_s;
        end
    end

    // Display shadow captured only at frame boundaries, plus frame_start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sh_r     <= {(4*NUM_DIGITS){1'b0}};
            dp_sh_r       <= {NUM_DIGITS{1'b0}};
            lz_sh_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_tick_s;
            if (frame_tick_s) begin
                data_sh_r <= data;
                dp_sh_r   <= dp;
                lz_sh_r   <= lz_blank;
            end
        end
    end

    // Registered display pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= SEL_OFF;
            seg_r <= SEG_OFF;
        end else begin
            sel_r <= sel_next_s;
            seg_r <= seg_next_s;
        end
    end

    assign SEG_S       = sel_r;
    assign SEG         = seg_r;
    assign frame_start = frame_start_r;

    seg_text_streamer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_text (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_tick_s),
        .data        (data),
        .blank_mask  (live_mask_s),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver: 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz_blank;
    logic [3:0]  SEG_S;
    logic [7:0]  SEG;
    logic        frame_start;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int check_cnt = 0;
    int pass_cnt  = 0;

    seg_scan_driver #(
        .NUM_DIGITS      (4),
        .SCAN_DIV        (8),
        .BLANK_CYCLES    (2),
        .SEG_ACTIVE_LOW  (1),
        .SEL_ACTIVE_HIGH (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data        (data),
        .dp          (dp),
        .lz_blank    (lz_blank),
        .SEG_S       (SEG_S),
        .SEG         (SEG),
        .frame_start (frame_start),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    // Advance to the negedge of the next frame_start cycle, bounded
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        check_cnt++;
        if (frame_start !== 1'b1) $display("FAIL %s_frame_wait frame_start=%b want 1", tag, frame_start);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; data = 16'h12AF; dp = 4'b0100; lz_blank = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++; if (SEG_S !== 4'b0000) $display("FAIL rst_sel got %b want 0000", SEG_S); else pass_cnt++;
        check_cnt++; if (SEG !== 8'hFF) $display("FAIL rst_seg got %h want ff", SEG); else pass_cnt++;
        check_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", tx_valid); else pass_cnt++;
        check_cnt++; if (tx_data !== 8'h00) $display("FAIL rst_txdata got %h want 00", tx_data); else pass_cnt++;
        check_cnt++; if (frame_start !== 1'b0) $display("FAIL rst_fs got %b want 0", frame_start); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++; if (frame_start !== 1'b1) $display("FAIL rst_first_fs got %b want 1", frame_start); else pass_cnt++;
        check_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h31)
            $display("FAIL rst_first_byte got v=%b d=%h want v=1 d=31", tx_valid, tx_data); else pass_cnt++;
    endtask

    task automatic test_basic;
        logic [7:0] exp_seg [4];
        logic [7:0] exp_tx [6];
        logic [3:0] exp_sel;
        logic [7:0] exp_s;
        exp_seg = '{8'h8E, 8'h88, 8'h24, 8'hF9};
        exp_tx  = '{8'h31, 8'h32, 8'h41, 8'h46, 8'h0D, 8'h0A};
        wait_frame("basic");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            exp_sel = ((c % 8) < 2) ? 4'b0000 : (4'b0001 << (c / 8));
            exp_s   = ((c % 8) < 2) ? 8'hFF : exp_seg[c / 8];
            check_cnt++; if (SEG_S !== exp_sel) $display("FAIL basic_sel c=%0d got %b want %b", c, SEG_S, exp_sel); else pass_cnt++;
            check_cnt++; if (SEG !== exp_s) $display("FAIL basic_seg c=%0d got %h want %h", c, SEG, exp_s); else pass_cnt++;
            if (c < 6) begin
                check_cnt++; if (tx_valid !== 1'b1 || tx_data !== exp_tx[c])
                    $display("FAIL basic_tx c=%0d got v=%b d=%h want v=1 d=%h", c, tx_valid, tx_data, exp_tx[c]); else pass_cnt++;
            end else if (c == 6) begin
                check_cnt++; if (tx_valid !== 1'b0) $display("FAIL basic_tx_end got v=%b want 0", tx_valid); else pass_cnt++;
            end
        end
        data = 16'h0030; dp = 4'b0000; lz_blank = 1'b1;
    endtask

    task automatic test_lz;
        logic [7:0] exp_seg [4];
        logic [7:0] exp_tx [6];
        exp_seg = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
        exp_tx  = '{8'h20, 8'h20, 8'h33, 8'h30, 8'h0D, 8'h0A};
        wait_frame("lz");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % 8) >= 2) begin
                check_cnt++; if (SEG !== exp_seg[c / 8]) $display("FAIL lz_seg c=%0d got %h want %h", c, SEG, exp_seg[c / 8]); else pass_cnt++;
            end
            if (c < 6) begin
                check_cnt++; if (tx_valid !== 1'b1 || tx_data !== exp_tx[c])
                    $display("FAIL lz_tx c=%0d got v=%b d=%h want v=1 d=%h", c, tx_valid, tx_data, exp_tx[c]); else pass_cnt++;
            end
        end
        data = 16'h0000;
        exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        exp_tx  = '{8'h20, 8'h20, 8'h20, 8'h30, 8'h0D, 8'h0A};
        wait_frame("lz0");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % 8) >= 2) begin
                check_cnt++; if (SEG !== exp_seg[c / 8]) $display("FAIL lz0_seg c=%0d got %h want %h", c, SEG, exp_seg[c / 8]); else pass_cnt++;
            end
            if (c < 4) begin
                check_cnt++; if (tx_data !== exp_tx[c]) $display("FAIL lz0_tx c=%0d got %h want %h", c, tx_data, exp_tx[c]); else pass_cnt++;
            end
        end
        data = 16'h12AF; dp = 4'b0100; lz_blank = 1'b0;
    endtask

    task automatic test_freeze;
        logic [7:0] old_seg [4];
        logic [7:0] new_seg [4];
        old_seg = '{8'h8E, 8'h88, 8'h24, 8'hF9};
        new_seg = '{8'hC0, 8'hB0, 8'h40, 8'hC0};
        wait_frame("freeze_a");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % 8) >= 2) begin
                check_cnt++; if (SEG !== old_seg[c / 8]) $display("FAIL freeze_hold c=%0d got %h want %h", c, SEG, old_seg[c / 8]); else pass_cnt++;
            end
            if (c == 10) data = 16'h0030;
        end
        wait_frame("freeze_b");
        check_cnt++; if (tx_data !== 8'h30) $display("FAIL freeze_tx got %h want 30", tx_data); else pass_cnt++;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % 8) >= 2) begin
                check_cnt++; if (SEG !== new_seg[c / 8]) $display("FAIL freeze_new c=%0d got %h want %h", c, SEG, new_seg[c / 8]); else pass_cnt++;
            end
        end
        data = 16'h12AF; dp = 4'b0000; lz_blank = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_tx [6];
        exp_tx = '{8'h31, 8'h32, 8'h41, 8'h46, 8'h0D, 8'h0A};
        wait_frame("bp");
        for (int c = 0; c < 39; c++) begin
            if (c > 0) @(negedge clk);
            check_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h31)
                $display("FAIL bp_hold c=%0d got v=%b d=%h want v=1 d=31", c, tx_valid, tx_data); else pass_cnt++;
            if (c == 32) begin
                check_cnt++; if (frame_start !== 1'b1) $display("FAIL bp_boundary got %b want 1", frame_start); else pass_cnt++;
            end
        end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check_cnt++; if (tx_valid !== 1'b1 || tx_data !== exp_tx[i])
                $display("FAIL bp_drain i=%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_tx[i]); else pass_cnt++;
        end
        for (int c = 45; c < 64; c++) begin
            @(negedge clk);
            check_cnt++; if (tx_valid !== 1'b0) $display("FAIL bp_no_record c=%0d got v=%b want 0", c, tx_valid); else pass_cnt++;
            if (c == 50) data = 16'h0030;
        end
        @(negedge clk);
        check_cnt++; if (frame_start !== 1'b1) $display("FAIL bp_next_fs got %b want 1", frame_start); else pass_cnt++;
        check_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h30)
            $display("FAIL bp_next_rec got v=%b d=%h want v=1 d=30", tx_valid, tx_data); else pass_cnt++;
    endtask

    task automatic test_blank_scan;
        logic [3:0] exp_sel;
        wait_frame("scan");
        for (int c = 0; c < 96; c++) begin
            if (c > 0) @(negedge clk);
            check_cnt++; if ($countones(SEG_S) > 1) $display("FAIL scan_onehot c=%0d got %b want <=1 bit", c, SEG_S); else pass_cnt++;
            exp_sel = ((c % 8) < 2) ? 4'b0000 : (4'b0001 << ((c / 8) % 4));
            check_cnt++; if (SEG_S !== exp_sel) $display("FAIL scan_sel c=%0d got %b want %b", c, SEG_S, exp_sel); else pass_cnt++;
            if ((c % 8) < 2) begin
                check_cnt++; if (SEG !== 8'hFF) $display("FAIL scan_blank c=%0d got %h want ff", c, SEG); else pass_cnt++;
            end
            check_cnt++; if (frame_start !== ((c % 32) == 0))
                $display("FAIL scan_fs c=%0d got %b want %b", c, frame_start, ((c % 32) == 0)); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        tx_ready = 1'b0;
        wait_frame("rmid");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_cnt++; if (SEG_S !== 4'b0000) $display("FAIL rmid_sel got %b want 0000", SEG_S); else pass_cnt++;
        check_cnt++; if (SEG !== 8'hFF) $display("FAIL rmid_seg got %h want ff", SEG); else pass_cnt++;
        check_cnt++; if (tx_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", tx_valid); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        check_cnt++; if (frame_start !== 1'b1) $display("FAIL rmid_fs got %b want 1", frame_start); else pass_cnt++;
        check_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h30)
            $display("FAIL rmid_byte got v=%b d=%h want v=1 d=30", tx_valid, tx_data); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (frame_start !== 1'b0) $display("FAIL rmid_fs_pulse got %b want 0", frame_start); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_freeze();
        test_back_to_back();
        test_blank_scan();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
